// File: rtl/booth_pkg.sv
// Shared types and helpers for the parametrised radix-4 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_digit_e;

    // Window is {b[2k+1], b[2k], b[2k-1]} of the extended multiplier.
    function automatic booth_digit_e booth_decode(input logic [2:0] win);
        booth_digit_e d;
        case (win)
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = M2;
            3'b101, 3'b110: d = M1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

    function automatic int num_digits(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_mult_param_if.sv
// Operand/result handshake bundle for booth_r4_mult_param.
interface booth_r4_mult_param_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic                 vld_in;
    logic                 rdy_in;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 is_signed;
    logic [TAG_W-1:0]     tag_in;
    logic                 vld_out;
    logic                 rdy_out;
    logic [2*WIDTH-1:0]   C;
    logic [TAG_W-1:0]     tag_out;

    modport master (
        output vld_in, A, B, is_signed, tag_in, rdy_out,
        input  rdy_in, vld_out, C, tag_out
    );

    modport slave (
        input  vld_in, A, B, is_signed, tag_in, rdy_out,
        output rdy_in, vld_out, C, tag_out
    );
endinterface

// File: rtl/booth_pp_gen.sv
// One Booth lane: selects 0, +/-M or +/-2M from a 3-bit multiplier window (unshifted).
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]                 win,
    input  logic signed [2*WIDTH+1:0]  mcand,
    output logic signed [2*WIDTH+1:0]  pp
);
    booth_digit_e dig;

    assign dig = booth_decode(win);

    always_comb begin
        pp = '0;
        case (dig)
            P1:      pp = mcand;
            P2:      pp = mcand <<< 1;
            M1:      pp = -mcand;
            M2:      pp = -(mcand <<< 1);
            default: pp = '0;
        endcase
    end
endmodule

// File: rtl/booth_r4_mult_param.sv
// Iterative radix-4 Booth multiplier retiring DPC digits per cycle behind valid/ready handshakes.
module booth_r4_mult_param
    import booth_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DPC   = 1,
    parameter int TAG_W = 4
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    booth_r4_mult_param_if.slave io
);
    localparam int ND    = num_digits(WIDTH);
    localparam int NCYC  = (ND + DPC - 1) / DPC;
    localparam int AW    = 2*WIDTH + 2;
    localparam int MW    = WIDTH + 3;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

    if ((WIDTH % 2) != 0 || WIDTH < 4 || DPC < 1 || DPC > ND || TAG_W < 1) begin : g_bad_param
        $error("booth_r4_mult_param: illegal parameters WIDTH=%0d DPC=%0d TAG_W=%0d",
               WIDTH, DPC, TAG_W);
    end

    state_e               state;
    logic [CNT_W-1:0]     cnt;
    logic signed [AW-1:0] mcand;
    logic [MW-1:0]        mplier;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;
    logic [TAG_W-1:0]     tag;
    logic                 rdy_in_r;
    logic                 vld_out_r;

    logic                 sgn_a;
    logic                 sgn_b;
    logic signed [AW-1:0] mcand_ext;
    logic [MW-1:0]        mplier_ext;
    logic signed [AW-1:0] pp [DPC];

    assign sgn_a      = io.is_signed & io.A[WIDTH-1];
    assign sgn_b      = io.is_signed & io.B[WIDTH-1];
    assign mcand_ext  = {{(WIDTH+2){sgn_a}}, io.A};
    assign mplier_ext = {{2{sgn_b}}, io.B, 1'b0};

    // mcand/mplier are pre-shifted each iteration, so lane j only needs a fixed 4^j weight.
    for (genvar j = 0; j < DPC; j++) begin : g_lane
        logic signed [AW-1:0] pp_raw;

        booth_pp_gen #(.WIDTH(WIDTH)) u_pp (
            .win   (mplier[2*j+2 -: 3]),
            .mcand (mcand),
            .pp    (pp_raw)
        );

        assign pp[j] = ((int'(cnt) * DPC + j) < ND) ? (pp_raw <<< (2*j)) : '0;
    end

    always_comb begin
        acc_next = acc;
        for (int j = 0; j < DPC; j++) begin
            acc_next = acc_next + pp[j];
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            tag       <= '0;
            rdy_in_r  <= 1'b1;
            vld_out_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.vld_in) begin
                        mcand    <= mcand_ext;
                        mplier   <= mplier_ext;
                        tag      <= io.tag_in;
                        acc      <= '0;
                        cnt      <= '0;
                        rdy_in_r <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << (2*DPC);
                    mplier <= mplier >> (2*DPC);
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NCYC-1)) begin
                        vld_out_r <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (io.rdy_out) begin
                        vld_out_r <= 1'b0;
                        rdy_in_r  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.rdy_in  = rdy_in_r;
    assign io.vld_out = vld_out_r;
    assign io.C       = acc[2*WIDTH-1:0];
    assign io.tag_out = tag;

endmodule

// File: tb/tb_booth_r4_mult_param.sv
// Directed and model-checked stimulus for booth_r4_mult_param across several WIDTH/DPC builds.
module tb_booth_r4_mult_param;

    logic CLK   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    booth_r4_mult_param_if #(.WIDTH(32), .TAG_W(4)) if0 ();
    booth_r4_mult_param_if #(.WIDTH(32), .TAG_W(4)) if1 ();
    booth_r4_mult_param_if #(.WIDTH(32), .TAG_W(4)) if2 ();
    booth_r4_mult_param_if #(.WIDTH(16), .TAG_W(4)) if3 ();

    booth_r4_mult_param #(.WIDTH(32), .DPC(1), .TAG_W(4)) dut0 (.CLK(CLK), .rst_n(rst_n), .io(if0));
    booth_r4_mult_param #(.WIDTH(32), .DPC(2), .TAG_W(4)) dut1 (.CLK(CLK), .rst_n(rst_n), .io(if1));
    booth_r4_mult_param #(.WIDTH(32), .DPC(4), .TAG_W(4)) dut2 (.CLK(CLK), .rst_n(rst_n), .io(if2));
    booth_r4_mult_param #(.WIDTH(16), .DPC(3), .TAG_W(4)) dut3 (.CLK(CLK), .rst_n(rst_n), .io(if3));

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    task automatic set_in(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [3:0] tg, input logic ro);
        case (sel)
            0: begin if0.vld_in = v; if0.A = a; if0.B = b; if0.is_signed = s; if0.tag_in = tg; if0.rdy_out = ro; end
            1: begin if1.vld_in = v; if1.A = a; if1.B = b; if1.is_signed = s; if1.tag_in = tg; if1.rdy_out = ro; end
            2: begin if2.vld_in = v; if2.A = a; if2.B = b; if2.is_signed = s; if2.tag_in = tg; if2.rdy_out = ro; end
            default: begin
                if3.vld_in = v; if3.A = a[15:0]; if3.B = b[15:0];
                if3.is_signed = s; if3.tag_in = tg; if3.rdy_out = ro;
            end
        endcase
    endtask

    task automatic get_out(input int sel, output logic ri, output logic vo,
                           output logic [63:0] c, output logic [3:0] t);
        case (sel)
            0: begin ri = if0.rdy_in; vo = if0.vld_out; c = if0.C; t = if0.tag_out; end
            1: begin ri = if1.rdy_in; vo = if1.vld_out; c = if1.C; t = if1.tag_out; end
            2: begin ri = if2.rdy_in; vo = if2.vld_out; c = if2.C; t = if2.tag_out; end
            default: begin ri = if3.rdy_in; vo = if3.vld_out; c = {32'b0, if3.C}; t = if3.tag_out; end
        endcase
    endtask

    function automatic int ncyc_of(input int sel);
        case (sel)
            0:       return 17;
            1:       return 9;
            2:       return 5;
            default: return 3;
        endcase
    endfunction

    // Plain integer multiply on sign/zero-extended operands.
    function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        longint     sa, sb;
        logic [63:0] p;
        if (w == 32) begin
            sa = s ? longint'($signed(a)) : longint'({32'b0, a});
            sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        end else begin
            sa = s ? longint'($signed(a[15:0])) : longint'({48'b0, a[15:0]});
            sb = s ? longint'($signed(b[15:0])) : longint'({48'b0, b[15:0]});
        end
        p = 64'(sa * sb);
        return (w == 32) ? p : {32'b0, p[31:0]};
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] msb, all;
        msb = (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
        all = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return msb;
            2:       return all;
            3:       return msb - 32'd1;
            4:       return 32'h1;
            default: return $urandom & all;
        endcase
    endfunction

    // Caller is #1 after a rising edge with the DUT idle; leaves it idle at the same phase.
    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [3:0] tg, input logic [63:0] expv, input int ncyc, input int stall);
        logic        ri, vo;
        logic [63:0] c;
        logic [3:0]  t;
        int          n;
        set_in(sel, 1'b1, a, b, s, tg, 1'b0);
        @(posedge CLK); #1;
        set_in(sel, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), 1'b0);
        get_out(sel, ri, vo, c, t);
        chk("busy_rdy_in", 64'(ri), 64'd0);
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
            get_out(sel, ri, vo, c, t);
        end while (!vo && n < 64);
        chk("latency", 64'(n), 64'(ncyc));
        chk("product", c, expv);
        chk("tag_out", 64'(t), 64'(tg));
        for (int i = 0; i < stall; i++) begin
            set_in(sel, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), 1'b0);
            @(posedge CLK); #1;
            get_out(sel, ri, vo, c, t);
            chk("stall_vld_rdy", {62'b0, vo, ri}, 64'b10);
            chk("stall_product", c, expv);
            chk("stall_tag", 64'(t), 64'(tg));
        end
        set_in(sel, 1'b1, $urandom, $urandom, 1'b1, 4'($urandom), 1'b1);
        @(posedge CLK); #1;
        get_out(sel, ri, vo, c, t);
        chk("release_vld_rdy", {62'b0, vo, ri}, 64'b01);
        set_in(sel, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        @(posedge CLK); #1;
        get_out(sel, ri, vo, c, t);
        chk("idle_vld_rdy", {62'b0, vo, ri}, 64'b01);
    endtask

    initial begin
        logic        ri, vo;
        logic [63:0] c;
        logic [3:0]  t;
        logic [31:0] ra, rb;
        logic        rs;
        logic [3:0]  rt;
        int          w;

        for (int s = 0; s < 4; s++) set_in(s, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        get_out(0, ri, vo, c, t);
        chk("reset_rdy_in", 64'(ri), 64'd1);
        chk("reset_vld_out", 64'(vo), 64'd0);
        chk("reset_C", c, 64'd0);
        chk("reset_tag_out", 64'(t), 64'd0);
        get_out(3, ri, vo, c, t);
        chk("reset16_C", c, 64'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) rst_n = 1'b1;
        @(posedge CLK); #1;

        run_op(0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 4'h5, 64'hFFFF_FFFF_FFFF_FFEB, 17, 5);
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h1, 64'hFFFF_FFFE_0000_0001, 17, 0);
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h2, 64'h0000_0000_0000_0001, 17, 0);
        run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 4'hC, 64'h4000_0000_0000_0000, 17, 1);
        run_op(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'hE, 64'hC000_0000_8000_0000, 17, 0);

        // Abort in the 8th BUSY cycle.
        set_in(0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 4'h9, 1'b0);
        @(posedge CLK); #1;
        set_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        repeat (7) @(posedge CLK);
        #3 rst_n = 1'b0;
        #1;
        get_out(0, ri, vo, c, t);
        chk("abort_rdy_in", 64'(ri), 64'd1);
        chk("abort_vld_out", 64'(vo), 64'd0);
        chk("abort_C", c, 64'd0);
        chk("abort_tag_out", 64'(t), 64'd0);
        @(negedge CLK) rst_n = 1'b1;
        repeat (20) begin
            @(posedge CLK); #1;
            get_out(0, ri, vo, c, t);
            chk("post_abort_idle", {62'b0, vo, ri}, 64'b01);
        end
        run_op(0, 32'h0000_0006, 32'hFFFF_FFFC, 1'b1, 4'h3, 64'hFFFF_FFFF_FFFF_FFE8, 17, 1);

        run_op(3, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 4'hA, 64'h0000_0000_FFFE_0001, 3, 2);
        run_op(3, 32'h0000_8000, 32'h0000_8000, 1'b1, 4'h4, 64'h0000_0000_4000_0000, 3, 0);
        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h6, 64'hFFFF_FFFE_0000_0001, 9, 1);
        run_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h7, 64'hFFFF_FFFE_0000_0001, 5, 1);
        run_op(2, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'h8, 64'hC000_0000_8000_0000, 5, 0);

        for (int sel = 0; sel < 4; sel++) begin
            w = (sel == 3) ? 16 : 32;
            for (int k = 0; k < 250; k++) begin
                ra = pick(w);
                rb = pick(w);
                rs = 1'($urandom_range(0, 1));
                rt = 4'($urandom);
                run_op(sel, ra, rb, rs, rt, ref_prod(w, ra, rb, rs), ncyc_of(sel), $urandom_range(0, 3));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/booth_r4_mult_param.md
Name: booth_r4_mult_param

Overview:
- Parametrised, iterative radix-4 Booth multiplier; next generation of the fixed 32-bit sequential multiplier.
- Adds generic operand width, configurable Booth digits retired per cycle, per-transaction signed/unsigned mode, and a pass-through tag.
- Sits behind a valid/ready handshake on both sides and drops into the datapath wherever the 32-bit unit is used today.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.
- DPC, 1, Booth digits processed per cycle; 1 <= DPC <= ND.
- TAG_W, 4, width of the opaque tag carried with each operation; must be >= 1.
- Derived, not overridable: ND = WIDTH/2 + 1 digits; NCYC = ceil(ND/DPC) iterations.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- vld_in  in  1  input operands valid
- rdy_in  out  1  block can accept an operation
- A  in  WIDTH  multiplicand
- B  in  WIDTH  multiplier
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned
- tag_in  in  TAG_W  tag captured with the operands
- vld_out  out  1  result valid
- rdy_out  in  1  downstream accepts the result
- C  out  2*WIDTH  product
- tag_out  out  TAG_W  tag of the operation whose result is on C

Behaviour:
- Reset state (async, while rst_n=0): state IDLE, rdy_in=1, vld_out=0, C=0, tag_out=0, counter=0, operand/tag registers=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: rdy_in=1. vld_in=1 at an edge means accept. On accept, capture A, B, is_signed, tag_in; clear the accumulator and counter; go to BUSY with rdy_in=0.
  - BUSY: on each edge, add DPC partial products to the accumulator and increment the counter. After the NCYC-th BUSY edge, go to DONE with vld_out=1.
  - DONE: C and tag_out are held stable. An edge with rdy_out=1 completes the handshake and returns to IDLE: vld_out=0, rdy_in=1.
- No same-cycle turnaround. An operation cannot be accepted on the output-handshake edge.
- Throughput: one operation per NCYC+2 cycles with rdy_out tied high.
- Latency: with the accept edge as E0, vld_out is first high after edge E_NCYC.
- rdy_in and vld_out are registered outputs derived from state only; neither depends combinationally on vld_in or rdy_out.
- vld_in during BUSY or DONE is ignored; A, B and tag_in may change freely then.
- Operand extension: the multiplier is extended to WIDTH+2 bits.
  - is_signed=1: sign-extend by 2 bits, then append the implicit 0 below the LSB.
  - is_signed=0: zero-extend by 2 bits, then append the implicit 0.
  - The multiplicand is sign- or zero-extended to 2*WIDTH+2 bits by the same rule.
- Digit k (0..ND-1) uses bits [2k+1:2k-1] of the extended multiplier.
  - Standard mapping: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
  - The partial product is weighted by 4^k.
- Accumulator is 2*WIDTH+2 bits, two's complement. C is the low 2*WIDTH bits and is exact for both modes.
- Final iteration: when ND is not a multiple of DPC, lanes with digit index >= ND contribute 0.
- C is driven from the accumulator. It is only meaningful while vld_out=1; intermediate values during BUSY are not guaranteed.
- Reset mid-operation: abort immediately (asynchronous) and return to the reset state. No partial result or vld_out pulse may appear.

Decomposition:
- Package booth_pkg:
  - state enum (IDLE, BUSY, DONE);
  - booth_digit_e encoding (ZERO, P1, P2, M1, M2);
  - function booth_decode(3-bit) -> booth_digit_e;
  - function num_digits(width) = width/2+1.
- Sub-module booth_pp_gen, instantiated DPC times, one per lane.
  - Inputs: 3-bit window, extended multiplicand.
  - Output: signed 2*WIDTH+2-bit partial product, unshifted.
  - The parent applies the 4^k weighting by lane and iteration.
- Top module owns the FSM, counter, operand/tag registers and accumulator.
- Parameter legality (WIDTH even, DPC range) is checked by an elaboration-time assertion.

Test Plan:
- Signed small, WIDTH=32, DPC=1 (NCYC=17): A=0xFFFFFFFD, B=7, is_signed=1, tag=0x5 -> C=0xFFFFFFFFFFFFFFEB, tag_out=0x5, vld_out first high after edge 17 following accept.
- Unsigned max, WIDTH=32: A=B=0xFFFFFFFF, is_signed=0 -> C=0xFFFFFFFE00000001; the same operands with is_signed=1 -> C=0x0000000000000001.
- Signed extremes, WIDTH=32: A=B=0x80000000, is_signed=1 -> C=0x4000000000000000; A=0x80000000, B=0x7FFFFFFF -> C=0xC000000080000000.
- Backpressure: hold rdy_out=0 for 5 cycles in DONE while toggling vld_in, A and B -> C, tag_out and vld_out stable, rdy_in=0 throughout; rdy_out=1 -> vld_out=0 and rdy_in=1 on the next edge.
- Reset mid-operation: drop rst_n at the 8th BUSY cycle -> vld_out=0 and rdy_in=1 asynchronously. A fresh op (A=6, B=-4 signed) after release -> C=0xFFFFFFFFFFFFFFE8.
- Parametric: WIDTH=16, DPC=3 (ND=9, NCYC=3): A=B=0xFFFF unsigned -> C=0xFFFE0001, vld_out after edge 3. Plus 1000 random signed/unsigned ops against a reference model, including rdy_out stalls, for DPC in {1,2,4}.
